// File: rtl/uart_tx_buffered.sv
// 8N1 serial transmitter with a small input FIFO; queued bytes go out back-to-back,
// LSB first, one bit every CLKS_PER_BIT clocks.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               tx_valid,
  input  logic [7:0]                         tx_data,
  output logic                               tx_ready,
  output logic                               tx,
  output logic                               tx_busy,
  output logic                               tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  state_t        state_q, state_n;
  logic [BW-1:0] baud_q, baud_n;
  logic [2:0]    bit_idx_q, bit_idx_n;
  logic [7:0]    shift_q, shift_n;
  logic          tx_q, tx_n;
  logic          done_q, done_n;
  logic          bit_end;

  assign tx_ready   = (count != FULL);
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count;
  assign tx         = tx_q;
  assign tx_done    = done_q;
  assign tx_busy    = (state_q != IDLE);
  assign bit_end    = (baud_q == BAUD_LAST);

  // Storage needs no reset: reset discards queued bytes by clearing the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      baud_q    <= baud_n;
      bit_idx_q <= bit_idx_n;
      shift_q   <= shift_n;
      tx_q      <= tx_n;
      done_q    <= done_n;
    end
  end

  // The STOP state pops the next byte on its final edge so frames abut with no idle gap.
  always_comb begin
    state_n   = state_q;
    baud_n    = baud_q;
    bit_idx_n = bit_idx_q;
    shift_n   = shift_q;
    tx_n      = tx_q;
    done_n    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          baud_n  = '0;
          tx_n    = 1'b0;
          state_n = START;
        end else begin
          tx_n = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n    = '0;
          tx_n      = shift_q[0];
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx_q != 3'd7) begin
            shift_n   = {1'b0, shift_q[7:1]};
            tx_n      = shift_q[1];
            bit_idx_n = bit_idx_q + 1'b1;
          end else begin
            tx_n    = 1'b1;
            state_n = STOP;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          done_n = 1'b1;
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Serial transmitter that is the counterpart of the board's UART receiver. It sends 8N1 frames at the same baud setting, 115200 baud from the 100 MHz clock.
- Bytes are accepted through a valid/ready handshake into a small FIFO and then serialized back-to-back.
- It sits in the CLK100MHZ domain of game_top. It sends game status bytes (bomb countdowns, game_over, power-up levels) to the host or remote controller.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100_000_000/115200).
- FIFO_DEPTH, 4: number of FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock (CLK100MHZ domain).
- rst_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  sender offers tx_data this cycle.
- tx_data  input  8  byte to send; sampled only when tx_valid && tx_ready.
- tx_ready  output  1  FIFO not full; equals (fifo_count != FIFO_DEPTH), combinational from registered count.
- tx  output  1  serial line; idle high; registered output.
- tx_busy  output  1  FSM is not in IDLE.
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of bytes queued, excluding the byte in flight.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, tx_busy=0, tx_done=0, fifo_count=0, tx_ready=1.
  - FSM goes to IDLE; baud counter, bit index and shift register are cleared.
  - Reset mid-frame aborts the frame: tx goes high immediately and queued bytes are discarded.
- Handshake:
  - Push happens on the edge where tx_valid && tx_ready.
  - tx_valid while tx_ready=0 is ignored, with no state change; the sender holds the data.
- FIFO:
  - Circular buffer with rd_ptr/wr_ptr of width $clog2(FIFO_DEPTH); pointers wrap naturally.
  - Push and pop on the same edge leave fifo_count unchanged.
  - When full, no push is accepted even if a pop occurs on the same edge, because tx_ready was 0 that cycle.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If fifo_count != 0, pop the head into the shift register, clear the baud counter and set tx=0. Next state is START.
  - Otherwise tx=1.
- Latency: a byte pushed at edge E into an empty FIFO with the FSM in IDLE pops at edge E+1, so tx falls at E+1.
- Baud counter counts 0..CLKS_PER_BIT-1. Each state ends on the edge where the counter equals CLKS_PER_BIT-1; the counter then resets to 0. Every bit lasts exactly CLKS_PER_BIT cycles.
- START: on bit end, tx=shift[0], bit index=0, next state DATA.
- DATA:
  - On bit end with bit index < 7: shift right, tx=next bit, increment bit index.
  - On bit end with bit index == 7: tx=1, next state STOP.
  - Bits are sent LSB first.
- STOP:
  - On bit end, tx_done=1 for one cycle.
  - If fifo_count != 0: pop, tx=0, next state START (no idle gap).
  - Otherwise tx=1, next state IDLE.
- Frame timing: 10*CLKS_PER_BIT cycles from the tx falling edge to the tx_done edge.
- Back-to-back frames have no gap: the next start bit begins on the same edge tx_done asserts.
- tx_busy is high from the popping edge until the return to IDLE, and stays continuously high across back-to-back frames.
- The baud counter width is $clog2(CLKS_PER_BIT). No arithmetic overflows: all counters are compared against their terminal values before incrementing.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated):
1. Reset with tx_valid=0 -> tx=1, tx_ready=1, tx_busy=0, fifo_count=0; the line stays high for 100 cycles.
2. Push 0xA5 at edge E -> tx=0 from E+1.
   - Data bits 1,0,1,0,0,1,0,1 follow, each held exactly 4 cycles.
   - Stop bit 1 follows.
   - tx_done pulses at edge E+41; tx_busy returns to 0 at the same edge.
3. Push 0x01..0x06 with tx_valid held high continuously from edge 0 -> 0x01 pops at edge 1.
   - fifo_count reaches 4 at edge 4 and tx_ready drops.
   - 0x06 is held until the pop at edge 41 frees space, then accepted at edge 42.
   - Six contiguous frames follow with no idle gap and tx_busy constantly 1; the receiver model decodes 0x01..0x06 in order.
4. Push and pop on the same edge: with fifo_count=2, push on the STOP-end pop edge -> fifo_count stays 2 and data order is preserved.
5. Assert rst_n=0 asynchronously mid-DATA (bit 3 of 0x00) -> tx=1 before the next clk edge.
   - FIFO is emptied and fifo_count=0.
   - After release, a new push of 0x3C transmits cleanly.
6. With CLKS_PER_BIT=868, push 0x55 -> frame duration is exactly 8680 cycles and the loopback uart_rx reports rx_byte=0x55 with an rx_dv pulse.
